// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stack_pkg
// Description : Shared defaults, decoded-operation enum and width helpers
//               for the parametrised LIFO (param_stack / stack_mem).
// Revision    : 1.0 - initial release
// ============================================================================
package stack_pkg;

    localparam int STK_DATA_W_DEF = 8;
    localparam int STK_DEPTH_DEF  = 32;

    // Stack-pointer / storage action decoded for the current cycle.
    // STK_PUSH also covers push+pop on an empty stack (push still happens).
    typedef enum logic [2:0] {
        STK_IDLE = 3'd0,
        STK_PUSH = 3'd1,
        STK_POP  = 3'd2,
        STK_REPL = 3'd3,
        STK_PEEK = 3'd4
    } stk_op_t;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int stk_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Storage address width for 0..depth-1.
    function automatic int stk_addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stack_mem.sv
`default_nettype none
// ============================================================================
// Module      : stack_mem
// Description : DATA_W x DEPTH register array for the LIFO. One synchronous
//               write port, two asynchronous read ports (top and next-of-top).
//               Contents are intentionally not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_top,
    output logic [DATA_W-1:0] o_rdata_top,
    input  logic [ADDR_W-1:0] i_raddr_nos,
    output logic [DATA_W-1:0] o_rdata_nos
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Single write port; the controller only ever presents in-range addresses.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_top = r_mem[i_raddr_top];
    assign o_rdata_nos = r_mem[i_raddr_nos];

endmodule
`default_nettype wire

// File: rtl/param_stack.sv
`default_nettype none
// ============================================================================
// Module      : param_stack
// Description : Parametrised LIFO with atomic replace, occupancy count,
//               full/empty status and sticky overflow/underflow flags.
//               Optional macro STACK_NOS_EN adds a registered next-of-stack
//               output (nos) loaded alongside dout.
// Revision    : 1.0 - initial release
// ============================================================================
module param_stack
    import stack_pkg::*;
#(
    parameter int DATA_W = STK_DATA_W_DEF,
    parameter int DEPTH  = STK_DEPTH_DEF,
    parameter int CNT_W  = stk_cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              tos,
    input  logic [DATA_W-1:0] din,
    input  logic              err_clr,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
`ifdef STACK_NOS_EN
    ,
    output logic [DATA_W-1:0] nos
`endif
);

    localparam int               c_addr_w = stk_addr_w(DEPTH);
    localparam logic [CNT_W-1:0] c_depth  = CNT_W'(DEPTH);

    logic [CNT_W-1:0]    r_sp;
    logic [DATA_W-1:0]   r_dout;
    logic                r_ovf;
    logic                r_unf;

    logic                w_empty;
    logic                w_full;
    stk_op_t             w_op;
    logic                w_rd;
    logic                w_we;
    logic                w_ovf_set;
    logic                w_unf_set;
    logic [c_addr_w-1:0] w_waddr;
    logic [c_addr_w-1:0] w_top_addr;
    logic [c_addr_w-1:0] w_nos_addr;
    logic [DATA_W-1:0]   w_top_data;
    logic [DATA_W-1:0]   w_nos_data;

    assign w_empty    = (r_sp == '0);
    assign w_full     = (r_sp == c_depth);
    assign w_top_addr = c_addr_w'(r_sp - CNT_W'(1));
    assign w_nos_addr = c_addr_w'(r_sp - CNT_W'(2));

    // Decode the request into a pointer/storage action plus read and error strobes.
    always_comb begin
        w_op = STK_IDLE;
        if (push && pop) begin
            w_op = w_empty ? STK_PUSH : STK_REPL;
        end else if (push) begin
            w_op = w_full ? STK_IDLE : STK_PUSH;
        end else if (pop) begin
            w_op = w_empty ? STK_IDLE : STK_POP;
        end else if (tos) begin
            w_op = w_empty ? STK_IDLE : STK_PEEK;
        end

        // Any read request against a non-empty stack captures the pre-edge top,
        // including push+tos, so din is never bypassed to dout.
        w_rd      = (pop || tos) && !w_empty;
        w_unf_set = (pop || tos) && w_empty;
        w_ovf_set = push && !pop && w_full;
        w_we      = !rst && ((w_op == STK_PUSH) || (w_op == STK_REPL));
        w_waddr   = (w_op == STK_REPL) ? w_top_addr : c_addr_w'(r_sp);
    end

    stack_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (c_addr_w)
    ) u_mem (
        .clk         (clk),
        .i_we        (w_we),
        .i_waddr     (w_waddr),
        .i_wdata     (din),
        .i_raddr_top (w_top_addr),
        .o_rdata_top (w_top_data),
        .i_raddr_nos (w_nos_addr),
        .o_rdata_nos (w_nos_data)
    );

    // Stack pointer moves only on a real push or pop; replace keeps it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp <= '0;
        end else begin
            case (w_op)
                STK_PUSH: r_sp <= r_sp + CNT_W'(1);
                STK_POP:  r_sp <= r_sp - CNT_W'(1);
                default:  r_sp <= r_sp;
            endcase
        end
    end

    // Registered read data; holds until the next successful read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
        end else if (w_rd) begin
            r_dout <= w_top_data;
        end
    end

    // Sticky error flags; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (err_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_unf_set) begin
                r_unf <= 1'b1;
            end else if (err_clr) begin
                r_unf <= 1'b0;
            end
        end
    end

`ifdef STACK_NOS_EN
    logic [DATA_W-1:0] r_nos;

    // Entry below the read top, or zero when fewer than two entries existed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nos <= '0;
        end else if (w_rd) begin
            r_nos <= (r_sp >= CNT_W'(2)) ? w_nos_data : '0;
        end
    end

    assign nos = r_nos;
`else
    logic w_unused_nos;
    assign w_unused_nos = ^w_nos_data;
`endif

    assign dout      = r_dout;
    assign count     = r_sp;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_param_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_stack
// Description : Scoreboard bench for param_stack (DATA_W=8, DEPTH=4) against
//               a queue-based LIFO reference model. Honours STACK_NOS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_stack;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam int CW = 3;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          push    = 1'b0;
    logic          pop     = 1'b0;
    logic          tos     = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] din     = '0;
    logic [DW-1:0] dout;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;
`ifdef STACK_NOS_EN
    logic [DW-1:0] nos;
`endif

    typedef struct packed {
        logic [DW-1:0] dout;
        logic [CW-1:0] count;
        logic          empty;
        logic          full;
        logic          ovf;
        logic          unf;
        logic [DW-1:0] nos;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] m_stk[$];
    logic [DW-1:0] m_dout = '0;
    logic [DW-1:0] m_nos  = '0;
    logic          m_ovf  = 1'b0;
    logic          m_unf  = 1'b0;
    int            n_checks = 0;
    int            n_fail   = 0;

    param_stack #(
        .DATA_W (DW),
        .DEPTH  (DP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .tos       (tos),
        .din       (din),
        .err_clr   (err_clr),
        .dout      (dout),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
`ifdef STACK_NOS_EN
        ,
        .nos       (nos)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and queue the state expected after the edge.
    task automatic step(input logic r, input logic pu, input logic po,
                        input logic to, input logic [DW-1:0] d, input logic cl);
        exp_t e;
        bit   was_empty;
        bit   was_full;
        rst = r; push = pu; pop = po; tos = to; din = d; err_clr = cl;
        if (r) begin
            m_stk.delete();
            m_dout = '0;
            m_nos  = '0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            was_empty = (m_stk.size() == 0);
            was_full  = (m_stk.size() == DP);
            if ((po || to) && !was_empty) begin
                m_dout = m_stk[m_stk.size()-1];
                m_nos  = (m_stk.size() >= 2) ? m_stk[m_stk.size()-2] : '0;
            end
            m_unf = ((po || to) && was_empty) || (m_unf && !cl);
            m_ovf = (pu && !po && was_full)   || (m_ovf && !cl);
            if (pu && po) begin
                if (was_empty) m_stk.push_back(d);
                else           m_stk[m_stk.size()-1] = d;
            end else if (pu) begin
                if (!was_full) m_stk.push_back(d);
            end else if (po && !was_empty) begin
                void'(m_stk.pop_back());
            end
        end
        e.dout  = m_dout;
        e.count = CW'(m_stk.size());
        e.empty = (m_stk.size() == 0);
        e.full  = (m_stk.size() == DP);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        e.nos   = m_nos;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_push(input logic [DW-1:0] d); step(0, 1, 0, 0, d, 0); endtask
    task automatic do_pop();                        step(0, 0, 1, 0, '0, 0); endtask
    task automatic do_tos();                        step(0, 0, 0, 1, '0, 0); endtask
    task automatic do_repl(input logic [DW-1:0] d); step(0, 1, 1, 0, d, 0); endtask
    task automatic do_idle();                       step(0, 0, 0, 0, '0, 0); endtask
    task automatic do_clr();                        step(0, 0, 0, 0, '0, 1); endtask
    task automatic do_rst();                        step(1, 0, 0, 0, '0, 0); endtask

    // Monitor: one expectation per clock, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("dout",      int'(dout),      int'(e.dout));
                check("count",     int'(count),     int'(e.count));
                check("empty",     int'(empty),     int'(e.empty));
                check("full",      int'(full),      int'(e.full));
                check("overflow",  int'(overflow),  int'(e.ovf));
                check("underflow", int'(underflow), int'(e.unf));
`ifdef STACK_NOS_EN
                check("nos",       int'(nos),       int'(e.nos));
`endif
            end
        end
    end

    initial begin
        @(negedge clk);
        do_rst(); do_rst();

        // Basic LIFO order
        do_push(8'h11); do_push(8'h22); do_push(8'h33);
        do_pop(); do_pop(); do_pop(); do_idle();

        // Fill, overflow, pop, clear
        for (int i = 1; i <= DP; i++) do_push(8'(i));
        do_push(8'h05); do_pop(); do_clr(); do_idle();

        // Underflow on empty, dout holds prior value
        do_push(8'hAA); do_pop();
        do_pop(); do_tos(); do_clr();

        // Replace on partial and full stack
        do_push(8'hA0); do_push(8'hB0); do_repl(8'hC0); do_tos();
        do_push(8'hD0); do_push(8'hE0); do_repl(8'hF0); do_tos(); do_idle();

        // push+pop on empty, push+tos same cycle
        do_rst(); do_repl(8'h5A); do_tos(); step(0, 1, 0, 1, 8'h6B, 0); do_tos();

        // Mid-sequence reset
        do_rst(); do_push(8'h01); do_push(8'h02); do_push(8'h03);
        do_rst(); do_pop(); do_idle();

        // Next-of-stack sequence
        do_rst(); do_push(8'h05); do_push(8'h07);
        do_tos(); do_pop(); do_pop(); do_idle();

        // Randomised traffic, with err_clr occasionally colliding with errors
        do_rst();
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 99) < 25),
                 8'($urandom),
                 ($urandom_range(0, 99) < 10));
        end
        do_idle();

        repeat (3) @(negedge clk);
        check("scoreboard_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
